// File: rtl/tqvp_dlmiles_i2c_fifo_ng.sv
// TX/RX byte FIFO pair between the CPU DATA/STAT registers and the I2C bit FSM.
// Circular buffers with natural-wrap pointers, a level counter per side,
// sticky overrun flags and registered watermark strobes.
module tqvp_dlmiles_i2c_fifo_ng #(
  parameter  int TX_W     = 9,
  parameter  int RX_W     = 8,
  parameter  int TX_DEPTH = 4,
  parameter  int RX_DEPTH = 4,
  localparam int TX_LW    = $clog2(TX_DEPTH) + 1,
  localparam int RX_LW    = $clog2(RX_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tx_flush_i,
  input  logic             rx_flush_i,
  input  logic             ovr_clear_i,
  input  logic [TX_W-1:0]  reg_data_send_i,
  input  logic             reg_data_send_valid_i,
  output logic [TX_W-1:0]  i2c_txd_data_o,
  output logic             i2c_txd_valid_o,
  input  logic             i2c_txd_ready_i,
  input  logic [RX_W-1:0]  i2c_rxd_data_i,
  input  logic             i2c_rxd_valid_i,
  output logic [RX_W:0]    reg_data_recv_o,
  input  logic             stb_data_recv_ready_i,
  input  logic [TX_LW-1:0] tx_thresh_i,
  input  logic [RX_LW-1:0] rx_thresh_i,
  output logic [TX_LW-1:0] tx_level_o,
  output logic [RX_LW-1:0] rx_level_o,
  output logic             st_tx_overrun_o,
  output logic             st_tx_full_o,
  output logic             st_tx_empty_o,
  output logic             st_rx_overrun_o,
  output logic             st_rx_full_o,
  output logic             st_rx_empty_o,
  output logic             stb_tx_lowwater_o,
  output logic             stb_rx_highwater_o
);
  localparam int TX_AW = $clog2(TX_DEPTH);
  localparam int RX_AW = $clog2(RX_DEPTH);
  localparam logic [TX_LW-1:0] TX_FULL_LVL = TX_LW'(TX_DEPTH);
  localparam logic [RX_LW-1:0] RX_FULL_LVL = RX_LW'(RX_DEPTH);

  // Storage is deliberately not reset; level/pointers define what is valid.
  logic [TX_W-1:0] tx_mem_q [TX_DEPTH];
  logic [RX_W-1:0] rx_mem_q [RX_DEPTH];

  logic [TX_AW-1:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
  logic [RX_AW-1:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
  logic [TX_LW-1:0] tx_level_q, tx_level_d;
  logic [RX_LW-1:0] rx_level_q, rx_level_d;
  logic             tx_ovr_q, tx_ovr_d, rx_ovr_q, rx_ovr_d;
  logic             tx_lw_q, tx_lw_d, rx_hw_q, rx_hw_d;
  logic             tx_full, tx_empty, rx_full, rx_empty;
  logic             tx_push, tx_pop, rx_push, rx_pop;

  assign tx_full  = (tx_level_q == TX_FULL_LVL);
  assign tx_empty = (tx_level_q == '0);
  assign rx_full  = (rx_level_q == RX_FULL_LVL);
  assign rx_empty = (rx_level_q == '0);

  // Push/pop decisions use pre-cycle state only; a pop never makes room for
  // a push in the same cycle.
  assign tx_push = reg_data_send_valid_i && !tx_full;
  assign tx_pop  = !tx_empty && i2c_txd_ready_i;
  assign rx_push = i2c_rxd_valid_i && !rx_full;
  assign rx_pop  = stb_data_recv_ready_i && !rx_empty;

  // TX next state: flush dominates; overrun set beats overrun clear.
  always_comb begin
    tx_wr_d    = tx_wr_q;
    tx_rd_d    = tx_rd_q;
    tx_level_d = tx_level_q;
    tx_ovr_d   = tx_ovr_q;
    if (tx_flush_i) begin
      tx_wr_d    = '0;
      tx_rd_d    = '0;
      tx_level_d = '0;
      tx_ovr_d   = 1'b0;
    end else begin
      if (tx_push) tx_wr_d = tx_wr_q + TX_AW'(1);
      if (tx_pop)  tx_rd_d = tx_rd_q + TX_AW'(1);
      if (tx_push && !tx_pop) tx_level_d = tx_level_q + TX_LW'(1);
      if (!tx_push && tx_pop) tx_level_d = tx_level_q - TX_LW'(1);
      tx_ovr_d = (reg_data_send_valid_i && tx_full) || (tx_ovr_q && !ovr_clear_i);
    end
    tx_lw_d = (tx_thresh_i != '0) && (tx_level_q > tx_thresh_i) && (tx_level_d <= tx_thresh_i);
  end

  // RX next state: same rules as TX, high-water crossing detected upward.
  always_comb begin
    rx_wr_d    = rx_wr_q;
    rx_rd_d    = rx_rd_q;
    rx_level_d = rx_level_q;
    rx_ovr_d   = rx_ovr_q;
    if (rx_flush_i) begin
      rx_wr_d    = '0;
      rx_rd_d    = '0;
      rx_level_d = '0;
      rx_ovr_d   = 1'b0;
    end else begin
      if (rx_push) rx_wr_d = rx_wr_q + RX_AW'(1);
      if (rx_pop)  rx_rd_d = rx_rd_q + RX_AW'(1);
      if (rx_push && !rx_pop) rx_level_d = rx_level_q + RX_LW'(1);
      if (!rx_push && rx_pop) rx_level_d = rx_level_q - RX_LW'(1);
      rx_ovr_d = (i2c_rxd_valid_i && rx_full) || (rx_ovr_q && !ovr_clear_i);
    end
    rx_hw_d = (rx_thresh_i != '0) && (rx_level_q < rx_thresh_i) && (rx_level_d >= rx_thresh_i);
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_wr_q    <= '0;
      tx_rd_q    <= '0;
      tx_level_q <= '0;
      tx_ovr_q   <= 1'b0;
      tx_lw_q    <= 1'b0;
      rx_wr_q    <= '0;
      rx_rd_q    <= '0;
      rx_level_q <= '0;
      rx_ovr_q   <= 1'b0;
      rx_hw_q    <= 1'b0;
    end else begin
      tx_wr_q    <= tx_wr_d;
      tx_rd_q    <= tx_rd_d;
      tx_level_q <= tx_level_d;
      tx_ovr_q   <= tx_ovr_d;
      tx_lw_q    <= tx_lw_d;
      rx_wr_q    <= rx_wr_d;
      rx_rd_q    <= rx_rd_d;
      rx_level_q <= rx_level_d;
      rx_ovr_q   <= rx_ovr_d;
      rx_hw_q    <= rx_hw_d;
    end
  end

  // Storage writes; a push coincident with a flush is discarded.
  always_ff @(posedge clk) begin
    if (tx_push && !tx_flush_i) tx_mem_q[tx_wr_q] <= reg_data_send_i;
    if (rx_push && !rx_flush_i) rx_mem_q[rx_wr_q] <= i2c_rxd_data_i;
  end

  assign i2c_txd_data_o     = tx_mem_q[tx_rd_q];
  assign i2c_txd_valid_o    = !tx_empty;
  assign reg_data_recv_o    = rx_empty ? {1'b1, {RX_W{1'b0}}} : {1'b0, rx_mem_q[rx_rd_q]};
  assign tx_level_o         = tx_level_q;
  assign rx_level_o         = rx_level_q;
  assign st_tx_overrun_o    = tx_ovr_q;
  assign st_tx_full_o       = tx_full;
  assign st_tx_empty_o      = tx_empty;
  assign st_rx_overrun_o    = rx_ovr_q;
  assign st_rx_full_o       = rx_full;
  assign st_rx_empty_o      = rx_empty;
  assign stb_tx_lowwater_o  = tx_lw_q;
  assign stb_rx_highwater_o = rx_hw_q;
endmodule

// File: tb/tb_tqvp_dlmiles_i2c_fifo_ng.sv
// Bench for tqvp_dlmiles_i2c_fifo_ng: directed scenarios then random traffic,
// all checked against a queue-based reference model.
module tb_tqvp_dlmiles_i2c_fifo_ng;
  localparam int TXD = 4, RXD = 4, TXW = 9, RXW = 8, TLW = 3, RLW = 3;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic           tx_flush = 0, rx_flush = 0, ovr_clear = 0;
  logic [TXW-1:0] send_data = '0;
  logic           send_valid = 0, txd_ready = 0;
  logic [RXW-1:0] rxd_data = '0;
  logic           rxd_valid = 0, rd_stb = 0;
  logic [TLW-1:0] tx_thresh = '0;
  logic [RLW-1:0] rx_thresh = '0;

  logic [TXW-1:0] txd_data;
  logic           txd_valid;
  logic [RXW:0]   recv;
  logic [TLW-1:0] tx_level;
  logic [RLW-1:0] rx_level;
  logic tx_ovr, tx_full, tx_empty, rx_ovr, rx_full, rx_empty, stb_lw, stb_hw;

  tqvp_dlmiles_i2c_fifo_ng #(.TX_W(TXW), .RX_W(RXW), .TX_DEPTH(TXD), .RX_DEPTH(RXD)) dut (
    .clk(clk), .rst_n(rst_n), .tx_flush_i(tx_flush), .rx_flush_i(rx_flush),
    .ovr_clear_i(ovr_clear), .reg_data_send_i(send_data), .reg_data_send_valid_i(send_valid),
    .i2c_txd_data_o(txd_data), .i2c_txd_valid_o(txd_valid), .i2c_txd_ready_i(txd_ready),
    .i2c_rxd_data_i(rxd_data), .i2c_rxd_valid_i(rxd_valid), .reg_data_recv_o(recv),
    .stb_data_recv_ready_i(rd_stb), .tx_thresh_i(tx_thresh), .rx_thresh_i(rx_thresh),
    .tx_level_o(tx_level), .rx_level_o(rx_level),
    .st_tx_overrun_o(tx_ovr), .st_tx_full_o(tx_full), .st_tx_empty_o(tx_empty),
    .st_rx_overrun_o(rx_ovr), .st_rx_full_o(rx_full), .st_rx_empty_o(rx_empty),
    .stb_tx_lowwater_o(stb_lw), .stb_rx_highwater_o(stb_hw));

  // Reference model: plain queues plus flags.
  logic [TXW-1:0] txq[$];
  logic [RXW-1:0] rxq[$];
  bit m_tovr, m_rovr, m_lw, m_hw;
  int n_pass = 0, n_tot = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    txq.delete(); rxq.delete();
    m_tovr = 0; m_rovr = 0; m_lw = 0; m_hw = 0;
  endtask

  task automatic model_step();
    int l0;
    if (!rst_n) begin model_reset(); return; end
    l0 = txq.size();
    if (tx_flush) begin
      txq.delete(); m_tovr = 0;
    end else begin
      m_tovr = (send_valid && l0 == TXD) || (m_tovr && !ovr_clear);
      if (l0 > 0 && txd_ready) void'(txq.pop_front());
      if (send_valid && l0 < TXD) txq.push_back(send_data);
    end
    m_lw = (tx_thresh != 0) && (l0 > int'(tx_thresh)) && (txq.size() <= int'(tx_thresh));
    l0 = rxq.size();
    if (rx_flush) begin
      rxq.delete(); m_rovr = 0;
    end else begin
      m_rovr = (rxd_valid && l0 == RXD) || (m_rovr && !ovr_clear);
      if (l0 > 0 && rd_stb) void'(rxq.pop_front());
      if (rxd_valid && l0 < RXD) rxq.push_back(rxd_data);
    end
    m_hw = (rx_thresh != 0) && (l0 < int'(rx_thresh)) && (rxq.size() >= int'(rx_thresh));
  endtask

  task automatic check_all();
    chk("tx_level", 32'(tx_level), 32'(txq.size()));
    chk("tx_empty", 32'(tx_empty), 32'(txq.size() == 0));
    chk("tx_full", 32'(tx_full), 32'(txq.size() == TXD));
    chk("txd_valid", 32'(txd_valid), 32'(txq.size() != 0));
    if (txq.size() != 0) chk("txd_data", 32'(txd_data), 32'(txq[0]));
    chk("tx_ovr", 32'(tx_ovr), 32'(m_tovr));
    chk("stb_lowwater", 32'(stb_lw), 32'(m_lw));
    chk("rx_level", 32'(rx_level), 32'(rxq.size()));
    chk("rx_empty", 32'(rx_empty), 32'(rxq.size() == 0));
    chk("rx_full", 32'(rx_full), 32'(rxq.size() == RXD));
    chk("recv", 32'(recv), rxq.size() == 0 ? 32'h100 : 32'(rxq[0]));
    chk("rx_ovr", 32'(rx_ovr), 32'(m_rovr));
    chk("stb_highwater", 32'(stb_hw), 32'(m_hw));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic idle();
    tx_flush = 0; rx_flush = 0; ovr_clear = 0; send_valid = 0;
    txd_ready = 0; rxd_valid = 0; rd_stb = 0;
  endtask

  logic [TXW-1:0] pat [4];

  initial begin
    pat[0] = 9'h101; pat[1] = 9'h0A5; pat[2] = 9'h03C; pat[3] = 9'h1FF;
    model_reset();
    #3 check_all();
    @(negedge clk) rst_n = 1'b1;

    // Asynchronous reset mid-operation.
    send_valid = 1;
    for (int i = 0; i < 3; i++) begin send_data = pat[i]; tick(); end
    send_valid = 0;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_rst_level", 32'(tx_level), 32'd0);
    chk("async_rst_empty", 32'(tx_empty), 32'd1);
    chk("async_rst_valid", 32'(txd_valid), 32'd0);
    tick();
    @(negedge clk) rst_n = 1'b1;

    // TX fill, overrun, drain order.
    send_valid = 1;
    for (int i = 0; i < 4; i++) begin send_data = pat[i]; tick(); end
    send_data = 9'h055; tick();
    send_valid = 0;
    chk("tx_full_after_fill", 32'(tx_full), 32'd1);
    chk("tx_ovr_after_fill", 32'(tx_ovr), 32'd1);
    txd_ready = 1;
    for (int i = 0; i < 4; i++) begin chk("tx_order", 32'(txd_data), 32'(pat[i])); tick(); end
    txd_ready = 0;
    chk("tx_empty_drained", 32'(tx_empty), 32'd1);
    ovr_clear = 1; tick(); ovr_clear = 0;
    chk("tx_ovr_cleared", 32'(tx_ovr), 32'd0);

    // Concurrent traffic at level 2 across pointer wrap.
    send_valid = 1;
    send_data = 9'($urandom); tick();
    send_data = 9'($urandom); tick();
    txd_ready = 1;
    for (int i = 0; i < 10; i++) begin
      send_data = 9'($urandom); tick();
      chk("level_steady", 32'(tx_level), 32'd2);
    end
    txd_ready = 0;
    send_data = 9'($urandom); tick();
    send_data = 9'($urandom); tick();
    txd_ready = 1; send_data = 9'h077; tick();
    chk("full_pushpop_level", 32'(tx_level), 32'd3);
    chk("full_pushpop_ovr", 32'(tx_ovr), 32'd1);
    send_valid = 0; tick();   // TX level 2, overrun still set
    txd_ready = 0;

    // Flush priority over a coincident push; RX flush leaves TX alone.
    rx_flush = 1; tick(); rx_flush = 0;
    chk("rx_flush_tx_intact", 32'(tx_level), 32'd2);
    tx_flush = 1; send_valid = 1; send_data = 9'h0EE; tick();
    idle();
    chk("flush_level", 32'(tx_level), 32'd0);
    chk("flush_ovr", 32'(tx_ovr), 32'd0);
    tick();
    chk("flush_push_absent", 32'(txd_valid), 32'd0);

    // RX path.
    rxd_valid = 1;
    rxd_data = 8'h11; tick();
    rxd_data = 8'h22; tick();
    rxd_valid = 0;
    chk("rx_head0", 32'(recv), 32'h011);
    rd_stb = 1; tick();
    chk("rx_head1", 32'(recv), 32'h022);
    tick();
    chk("rx_empty_read", 32'(recv), 32'h100);
    tick();
    chk("rx_extra_read", 32'(recv), 32'h100);
    chk("rx_extra_no_ovr", 32'(rx_ovr), 32'd0);
    rd_stb = 0; rxd_valid = 1;
    for (int i = 1; i <= 5; i++) begin rxd_data = 8'(i); tick(); end
    rxd_valid = 0;
    chk("rx_ovr_set", 32'(rx_ovr), 32'd1);
    chk("rx_ovr_head", 32'(recv), 32'h001);
    ovr_clear = 1; tick(); ovr_clear = 0;
    chk("rx_ovr_clear", 32'(rx_ovr), 32'd0);
    rx_flush = 1; tick(); rx_flush = 0;

    // Watermarks.
    rx_thresh = 3; rxd_valid = 1;
    for (int i = 0; i < 3; i++) begin rxd_data = 8'($urandom); tick(); end
    chk("rx_hw_pulse", 32'(stb_hw), 32'd1);
    tick();
    rxd_valid = 0;
    chk("rx_hw_no_pulse", 32'(stb_hw), 32'd0);
    tx_thresh = 1; send_valid = 1;
    for (int i = 0; i < 3; i++) begin send_data = 9'($urandom); tick(); end
    send_valid = 0; txd_ready = 1;
    tick(); chk("tx_lw_at2", 32'(stb_lw), 32'd0);
    tick(); chk("tx_lw_at1", 32'(stb_lw), 32'd1);
    tx_thresh = 0;
    tick(); chk("tx_lw_disabled", 32'(stb_lw), 32'd0);
    idle();

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      send_valid = ($urandom_range(0, 99) < 55);
      send_data  = 9'($urandom);
      txd_ready  = ($urandom_range(0, 99) < 45);
      rxd_valid  = ($urandom_range(0, 99) < 50);
      rxd_data   = 8'($urandom);
      rd_stb     = ($urandom_range(0, 99) < 45);
      tx_flush   = ($urandom_range(0, 99) < 3);
      rx_flush   = ($urandom_range(0, 99) < 3);
      ovr_clear  = ($urandom_range(0, 99) < 5);
      if ($urandom_range(0, 19) == 0) tx_thresh = 3'($urandom);
      if ($urandom_range(0, 19) == 0) rx_thresh = 3'($urandom);
      tick();
    end
    idle();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
